// File: rtl/msc_pkg.sv
// Shared FSM state type and result error codes for multi_sensor_core.
package msc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CHECK,
        ST_TRIG,
        ST_WAIT_RISE,
        ST_MEASURE,
        ST_GAP
    } msc_state_t;

    localparam logic [1:0] ERR_OK      = 2'd0;
    localparam logic [1:0] ERR_TIMEOUT = 2'd1;
    localparam logic [1:0] ERR_STUCK   = 2'd2;
    localparam logic [1:0] ERR_OVF     = 2'd3;

endpackage

// File: rtl/msc_us_cnt.sv
// Saturating microsecond tick counter with clear and terminal compare.
// term flags the tick that brings the count up to limit.
module msc_us_cnt #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk_sys,
    input  logic             rst,
    input  logic             clr,
    input  logic             tick,
    input  logic [CNT_W-1:0] limit,
    output logic [CNT_W-1:0] cnt,
    output logic             term
);

    assign term = tick && (({1'b0, cnt} + (CNT_W+1)'(1)) >= {1'b0, limit});

    always_ff @(posedge clk_sys) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (tick && !(&cnt)) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/multi_sensor_core.sv
// Multi-channel trig/echo ranging engine: single-shot and round-robin scan modes.
// Define MSC_ERRCNT_EN to add per-channel saturating error counters (err_clr/err_cnt).
module multi_sensor_core
    import msc_pkg::*;
#(
    parameter int unsigned N_CH       = 4,
    parameter int unsigned CH_W       = 2,
    parameter int unsigned CNT_W      = 16,
    parameter int unsigned TRIG_US    = 10,
    parameter int unsigned TIMEOUT_US = 30000,
    parameter int unsigned MAX_US     = 25000,
    parameter int unsigned GAP_US     = 60000
) (
    input  logic              clk_sys,
    input  logic              rst,
    input  logic              pluse_us,
    input  logic [N_CH-1:0]   echo,
    output logic [N_CH-1:0]   trig,
    input  logic              fire_measure,
    input  logic [CH_W-1:0]   fire_ch,
    input  logic              scan_en,
    input  logic [N_CH-1:0]   ch_mask,
    output logic              busy,
    output logic              done_measure,
    output logic              err_measure,
    output logic [1:0]        err_code,
    output logic [CNT_W-1:0]  data_measure,
    output logic [CH_W-1:0]   ch_measure
`ifdef MSC_ERRCNT_EN
    ,
    input  logic              err_clr,
    output logic [N_CH*8-1:0] err_cnt
`endif
);

    localparam logic [CNT_W-1:0] TRIG_L    = CNT_W'(TRIG_US);
    localparam logic [CNT_W-1:0] TIMEOUT_L = CNT_W'(TIMEOUT_US);
    localparam logic [CNT_W-1:0] MAX_L     = CNT_W'(MAX_US);
    localparam logic [CNT_W-1:0] GAP_L     = CNT_W'(GAP_US);

    msc_state_t       state, state_d;
    logic [CH_W-1:0]  ch_q, ch_d, ptr_q, ptr_d, scan_pick, chm_d;
    logic             scan_q, scan_d, found;
    logic [N_CH-1:0]  trig_d;
    logic             done_d, err_d;
    logic [1:0]       code_d;
    logic [CNT_W-1:0] data_d, cnt, limit;
    logic             echo_bit, cnt_tick, cnt_clr, term, fire_ok;
    int unsigned      idx;

    assign busy     = (state != ST_IDLE);
    assign echo_bit = echo[ch_q];
    assign fire_ok  = (32'(fire_ch) < N_CH);
    // Width counting only advances while the echo is high.
    assign cnt_tick = pluse_us && ((state != ST_MEASURE) || echo_bit);
    assign cnt_clr  = (state_d != state);

    msc_us_cnt #(.CNT_W(CNT_W)) u_us_cnt (
        .clk_sys (clk_sys),
        .rst     (rst),
        .clr     (cnt_clr),
        .tick    (cnt_tick),
        .limit   (limit),
        .cnt     (cnt),
        .term    (term)
    );

    always_comb begin
        scan_pick = ptr_q;
        found     = 1'b0;
        idx       = 0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            idx = (32'(ptr_q) + i) % N_CH;
            if (!found && ch_mask[CH_W'(idx)]) begin
                scan_pick = CH_W'(idx);
                found     = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state;
        ch_d    = ch_q;
        ptr_d   = ptr_q;
        scan_d  = scan_q;
        trig_d  = trig;
        done_d  = 1'b0;
        err_d   = 1'b0;
        code_d  = err_code;
        data_d  = data_measure;
        chm_d   = ch_measure;
        limit   = '1;
        case (state)
            ST_IDLE: begin
                if (scan_en && (|ch_mask)) begin
                    ch_d    = scan_pick;
                    scan_d  = 1'b1;
                    state_d = ST_CHECK;
                end else if (fire_measure && fire_ok) begin
                    ch_d    = fire_ch;
                    scan_d  = 1'b0;
                    state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (echo_bit) begin
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                    code_d  = ERR_STUCK;
                    data_d  = '0;
                    chm_d   = ch_q;
                    state_d = ST_GAP;
                end else begin
                    trig_d       = '0;
                    trig_d[ch_q] = 1'b1;
                    state_d      = ST_TRIG;
                end
            end
            ST_TRIG: begin
                limit = TRIG_L;
                if (term) begin
                    trig_d  = '0;
                    state_d = ST_WAIT_RISE;
                end
            end
            ST_WAIT_RISE: begin
                limit = TIMEOUT_L;
                if (echo_bit) begin
                    state_d = ST_MEASURE;
                end else if (term) begin
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                    code_d  = ERR_TIMEOUT;
                    data_d  = '0;
                    chm_d   = ch_q;
                    state_d = ST_GAP;
                end
            end
            ST_MEASURE: begin
                limit = MAX_L;
                if (!echo_bit) begin
                    done_d  = 1'b1;
                    code_d  = ERR_OK;
                    data_d  = cnt;
                    chm_d   = ch_q;
                    state_d = ST_GAP;
                end else if (term) begin
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                    code_d  = ERR_OVF;
                    data_d  = MAX_L;
                    chm_d   = ch_q;
                    state_d = ST_GAP;
                end
            end
            ST_GAP: begin
                limit = GAP_L;
                if (term) begin
                    state_d = ST_IDLE;
                    if (scan_q) begin
                        ptr_d = (32'(ch_q) == N_CH - 1) ? '0 : ch_q + CH_W'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (rst) begin
            state        <= ST_IDLE;
            ch_q         <= '0;
            ptr_q        <= '0;
            scan_q       <= 1'b0;
            trig         <= '0;
            done_measure <= 1'b0;
            err_measure  <= 1'b0;
            err_code     <= ERR_OK;
            data_measure <= '0;
            ch_measure   <= '0;
        end else begin
            state        <= state_d;
            ch_q         <= ch_d;
            ptr_q        <= ptr_d;
            scan_q       <= scan_d;
            trig         <= trig_d;
            done_measure <= done_d;
            err_measure  <= err_d;
            err_code     <= code_d;
            data_measure <= data_d;
            ch_measure   <= chm_d;
        end
    end

`ifdef MSC_ERRCNT_EN
    // err_measure and ch_measure are registered together, so ch_measure names the erring channel.
    always_ff @(posedge clk_sys) begin
        if (rst || err_clr) begin
            err_cnt <= '0;
        end else begin
            for (int unsigned i = 0; i < N_CH; i++) begin
                if (err_measure && (32'(ch_measure) == i) && (err_cnt[i*8 +: 8] != 8'hFF)) begin
                    err_cnt[i*8 +: 8] <= err_cnt[i*8 +: 8] + 8'd1;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_multi_sensor_core.sv
// Randomized self-checking bench for multi_sensor_core against a result-level model.
`timescale 1ns/1ps
module tb_multi_sensor_core;

    localparam int N_CH       = 4;
    localparam int CH_W       = 2;
    localparam int CNT_W      = 16;
    localparam int TRIG_US    = 10;
    localparam int TIMEOUT_US = 50;
    localparam int MAX_US     = 200;
    localparam int GAP_US     = 20;

    localparam int K_NORM    = 0;
    localparam int K_TIMEOUT = 1;
    localparam int K_STUCK   = 2;

    logic             clk_sys = 1'b0;
    logic             rst = 1'b1;
    logic             pluse_us = 1'b0;
    logic [N_CH-1:0]  echo = '0;
    logic [N_CH-1:0]  trig;
    logic             fire_measure = 1'b0;
    logic [CH_W-1:0]  fire_ch = '0;
    logic             scan_en = 1'b0;
    logic [N_CH-1:0]  ch_mask = '0;
    logic             busy, done_measure, err_measure;
    logic [1:0]       err_code;
    logic [CNT_W-1:0] data_measure;
    logic [CH_W-1:0]  ch_measure;
`ifdef MSC_ERRCNT_EN
    logic             err_clr = 1'b0;
    logic [N_CH*8-1:0] err_cnt;
`endif

    typedef struct {
        int ch;
        int code;
        int data;
        int err;
        int at;
    } res_t;

    res_t res_q[$];
    int   checks = 0;
    int   errors = 0;
    int   ticks = 0;
    int   div = 0;
    int   trig_bad = 0;
    int   err_bad = 0;

    multi_sensor_core #(
        .N_CH(N_CH), .CH_W(CH_W), .CNT_W(CNT_W), .TRIG_US(TRIG_US),
        .TIMEOUT_US(TIMEOUT_US), .MAX_US(MAX_US), .GAP_US(GAP_US)
    ) dut (
        .clk_sys(clk_sys), .rst(rst), .pluse_us(pluse_us), .echo(echo), .trig(trig),
        .fire_measure(fire_measure), .fire_ch(fire_ch), .scan_en(scan_en), .ch_mask(ch_mask),
        .busy(busy), .done_measure(done_measure), .err_measure(err_measure),
        .err_code(err_code), .data_measure(data_measure), .ch_measure(ch_measure)
`ifdef MSC_ERRCNT_EN
        , .err_clr(err_clr), .err_cnt(err_cnt)
`endif
    );

    always #5 clk_sys = ~clk_sys;

    always @(negedge clk_sys) begin
        div = (div == 3) ? 0 : div + 1;
        pluse_us = (div == 0);
    end

    always @(posedge clk_sys) begin
        if (pluse_us) ticks = ticks + 1;
    end

    always @(negedge clk_sys) begin
        if (done_measure === 1'b1) begin
            res_t r;
            r.ch   = int'(ch_measure);
            r.code = int'(err_code);
            r.data = int'(data_measure);
            r.err  = int'(err_measure);
            r.at   = ticks;
            res_q.push_back(r);
        end
        if (err_measure !== (done_measure && (err_code != 2'd0))) err_bad++;
        if (!$onehot0(trig)) trig_bad++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk_sys);
        #1;
    endtask

    task automatic wait_tick_edges(input int n);
        repeat (n) begin
            @(posedge clk_sys);
            while (!pluse_us) @(posedge clk_sys);
        end
        step();
    endtask

    task automatic wait_idle();
        int n = 0;
        step();
        while (busy !== 1'b0 && n < 5000) begin
            step();
            n++;
        end
        if (n >= 5000) check("idle_timeout", 32'(busy), 0);
    endtask

    task automatic get_result(output res_t r, output bit ok);
        int n = 0;
        while (res_q.size() == 0 && n < 4000) begin
            step();
            n++;
        end
        ok = (res_q.size() != 0);
        if (ok) r = res_q.pop_front();
        else begin
            r = '{default: 0};
            check("result_timeout", 0, 1);
        end
    endtask

    function automatic int next_scan(input logic [N_CH-1:0] mask, input int ptr);
        for (int i = 0; i < N_CH; i++) begin
            if (mask[(ptr + i) % N_CH]) return (ptr + i) % N_CH;
        end
        return -1;
    endfunction

    task automatic run_one(input int ch, input int kind, input int dly, input int width);
        int   n, tlen, t_fall, t_rise, exp_code, exp_data;
        res_t r;
        bit   ok;
        wait_idle();
        t_rise = 0;
        if (kind == K_STUCK) echo[ch] = 1'b1;
        fire_ch = CH_W'(ch);
        fire_measure = 1'b1;
        step();
        fire_measure = 1'b0;
        check("busy_after_fire", 32'(busy), 1);
        if (kind == K_STUCK) begin
            step();
            check("stuck_latency", res_q.size(), 1);
            check("stuck_no_trig", 32'(trig), 0);
            get_result(r, ok);
            echo[ch] = 1'b0;
        end else begin
            n = 0;
            while (trig[ch] !== 1'b1 && n < 20) begin step(); n++; end
            tlen = 0;
            while (trig[ch] === 1'b1 && tlen < 100) begin step(); tlen++; end
            check("trig_len", 32'(tlen >= (TRIG_US - 1) * 4 + 1 && tlen <= TRIG_US * 4), 1);
            t_fall = ticks;
            if (kind == K_NORM) begin
                wait_tick_edges(dly);
                echo[ch] = 1'b1;
                t_rise = ticks;
                wait_tick_edges(width);
                echo[ch] = 1'b0;
            end
            get_result(r, ok);
            if (ok && kind == K_TIMEOUT) check("timeout_ticks", r.at - t_fall, TIMEOUT_US);
            if (ok && kind == K_NORM) check("result_ticks", r.at - t_rise, (width >= MAX_US) ? MAX_US : width);
        end
        if (kind == K_STUCK)        begin exp_code = 2; exp_data = 0; end
        else if (kind == K_TIMEOUT) begin exp_code = 1; exp_data = 0; end
        else if (width >= MAX_US)   begin exp_code = 3; exp_data = MAX_US; end
        else                        begin exp_code = 0; exp_data = width; end
        if (ok) begin
            check("res_ch", r.ch, ch);
            check("res_code", r.code, exp_code);
            check("res_data", r.data, exp_data);
            check("res_err", r.err, (exp_code != 0) ? 1 : 0);
        end
        wait_idle();
        check("no_extra_done", res_q.size(), 0);
    endtask

    initial begin
        res_t r;
        bit   ok;
        int   exp_ptr, exp_ch, prev_at, n;

        repeat (4) step();
        check("rst_trig", 32'(trig), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done_measure), 0);
        check("rst_err", 32'(err_measure), 0);
        check("rst_code", 32'(err_code), 0);
        check("rst_data", 32'(data_measure), 0);
        check("rst_ch", 32'(ch_measure), 0);
        rst = 1'b0;
        step();

        run_one(2, K_NORM, 5, 120);
        run_one(1, K_TIMEOUT, 0, 0);
        run_one(0, K_STUCK, 0, 0);
        run_one(3, K_NORM, 2, 300);
        run_one(1, K_NORM, 0, MAX_US - 1);
        run_one(2, K_NORM, 45, MAX_US);

        for (int i = 0; i < 10; i++) begin
            int sel, ch;
            sel = int'($urandom_range(0, 9));
            ch  = int'($urandom_range(0, N_CH - 1));
            if (sel == 0)      run_one(ch, K_STUCK, 0, 0);
            else if (sel == 1) run_one(ch, K_TIMEOUT, 0, 0);
            else if (sel == 2) run_one(ch, K_NORM, int'($urandom_range(0, 45)), int'($urandom_range(MAX_US, MAX_US + 40)));
            else               run_one(ch, K_NORM, int'($urandom_range(0, 45)), int'($urandom_range(1, 150)));
        end

        // Reset in the middle of a width measurement: no result may follow.
        wait_idle();
        fire_ch = 2'd3;
        fire_measure = 1'b1;
        step();
        fire_measure = 1'b0;
        n = 0;
        while (trig[3] !== 1'b1 && n < 20) begin step(); n++; end
        n = 0;
        while (trig[3] === 1'b1 && n < 100) begin step(); n++; end
        wait_tick_edges(3);
        echo[3] = 1'b1;
        wait_tick_edges(30);
        rst = 1'b1;
        step();
        check("midrst_trig", 32'(trig), 0);
        check("midrst_busy", 32'(busy), 0);
        check("midrst_done", 32'(done_measure), 0);
        check("midrst_data", 32'(data_measure), 0);
        rst = 1'b0;
        echo = '0;
        repeat (400) step();
        check("midrst_no_result", res_q.size(), 0);

`ifdef MSC_ERRCNT_EN
        check("errcnt_after_rst", 32'(err_cnt), 0);
        repeat (3) run_one(1, K_TIMEOUT, 0, 0);
        check("errcnt_ch1", 32'(err_cnt[15:8]), 3);
        check("errcnt_others", 32'({err_cnt[31:16], err_cnt[7:0]}), 0);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        step();
        check("errcnt_clr", 32'(err_cnt), 0);
`endif

        wait_idle();
        exp_ptr = 0;
        prev_at = 0;
        ch_mask = 4'b1011;
        scan_en = 1'b1;
        for (int k = 0; k < 5; k++) begin
            if (k == 4) begin
                n = 0;
                while (trig === '0 && n < 2000) begin step(); n++; end
                scan_en = 1'b0;
            end
            get_result(r, ok);
            exp_ch = next_scan(ch_mask, exp_ptr);
            if (ok) begin
                check("scan_ch", r.ch, exp_ch);
                check("scan_code", r.code, 1);
                if (k > 0) check("scan_spacing", r.at - prev_at, GAP_US + TRIG_US + TIMEOUT_US);
                prev_at = r.at;
            end
            exp_ptr = (exp_ch + 1) % N_CH;
            if (k == 1) begin
                fire_ch = 2'd2;
                fire_measure = 1'b1;
                step();
                fire_measure = 1'b0;
            end
        end
        wait_idle();
        repeat (400) step();
        check("scan_stopped", res_q.size(), 0);
        check("scan_idle", 32'(busy), 0);

        check("trig_onehot", trig_bad, 0);
        check("err_consistent", err_bad, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
